// File: rtl/incr_checker.sv
// ---------------------------------------------------------------------------
// incr_checker
//
// Sits directly downstream of the example top-level. It samples the
// stimulus that block receives and the results it produces, and checks each
// result against the modular increment of its input. It keeps pass/error
// statistics and records which lanes failed first. When STOP_ON_ERR is set,
// it freezes on the first failure, so a software harness only has to read a
// few registers.
//
// Parameters
//   SMALL_W, QUAD_W, WIDE_W : lane widths
//   WARMUP                  : cycles spent in WARMUP before checking (>= 1)
//   CNT_W                   : width of check_cnt / err_cnt (saturating)
//   STOP_ON_ERR             : 1 = enter FAIL on first mismatch, freeze stats
//
// Ports
//   clk            in   clock, rising edge
//   reset_l        in   asynchronous active-low reset
//   enable         in   1 = monitor active, 0 = return to IDLE (stats held)
//   clear          in   synchronous clear of stats, returns to IDLE
//   in_small/quad/wide   in   stimulus applied to the upstream block
//   out_small/quad/wide  in   results from the upstream block
//   state          out  0 IDLE, 1 WARMUP, 2 CHECK, 3 FAIL
//   check_cnt      out  CHECK cycles sampled (saturating)
//   err_cnt        out  CHECK cycles with >= 1 lane mismatch (saturating)
//   err_flag       out  sticky, set on first mismatch
//   first_err_lane out  {wide, quad, small} mismatch vector of first error
//   mismatch       out  registered mismatch vector of last CHECK cycle
// ---------------------------------------------------------------------------
module incr_checker #(
  parameter int SMALL_W     = 2,
  parameter int QUAD_W      = 40,
  parameter int WIDE_W      = 70,
  parameter int WARMUP      = 2,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               enable,
  input  logic               clear,
  input  logic [SMALL_W-1:0] in_small,
  input  logic [QUAD_W-1:0]  in_quad,
  input  logic [WIDE_W-1:0]  in_wide,
  input  logic [SMALL_W-1:0] out_small,
  input  logic [QUAD_W-1:0]  out_quad,
  input  logic [WIDE_W-1:0]  out_wide,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   check_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               err_flag,
  output logic [2:0]         first_err_lane,
  output logic [2:0]         mismatch
);

  // The warmup counter only has to hold WARMUP-1.
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  state_t            state_reg,  state_next;
  logic [WARM_W-1:0] warm_reg,   warm_next;
  logic [CNT_W-1:0]  chk_reg,    chk_next;
  logic [CNT_W-1:0]  err_reg,    err_next;
  logic              flag_reg,   flag_next;
  logic [2:0]        first_reg,  first_next;
  logic [2:0]        mis_reg,    mis_next;

  // -------------------------------------------------------------------------
  // Expected values: increment at each lane's own width, so the carry-out
  // falls off and an all-ones input expects zero.
  // -------------------------------------------------------------------------
  logic [SMALL_W-1:0] exp_small;
  logic [QUAD_W-1:0]  exp_quad;
  logic [WIDE_W-1:0]  exp_wide;
  logic [2:0]         lane_mis;

  assign exp_small = in_small + SMALL_W'(1);
  assign exp_quad  = in_quad  + QUAD_W'(1);
  assign exp_wide  = in_wide  + WIDE_W'(1);

  assign lane_mis = {(out_wide  != exp_wide),
                     (out_quad  != exp_quad),
                     (out_small != exp_small)};

  // -------------------------------------------------------------------------
  // Next-state and statistics update.
  // Priority: clear, then enable=0, then the per-state behaviour.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    warm_next  = warm_reg;
    chk_next   = chk_reg;
    err_next   = err_reg;
    flag_next  = flag_reg;
    first_next = first_reg;
    mis_next   = mis_reg;

    if (clear) begin
      state_next = ST_IDLE;
      warm_next  = '0;
      chk_next   = '0;
      err_next   = '0;
      flag_next  = 1'b0;
      first_next = '0;
      mis_next   = '0;
    end else if (!enable) begin
      // Statistics are held so the harness can still read them.
      state_next = ST_IDLE;
      warm_next  = '0;
      mis_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_WARMUP;
          warm_next  = WARM_LOAD;
          mis_next   = '0;
        end

        ST_WARMUP: begin
          mis_next = '0;
          if (warm_reg == '0) begin
            state_next = ST_CHECK;
          end else begin
            warm_next = warm_reg - WARM_W'(1);
          end
        end

        ST_CHECK: begin
          mis_next = lane_mis;
          if (chk_reg != CNT_MAX) begin
            chk_next = chk_reg + CNT_W'(1);
          end
          if (lane_mis != 3'b000) begin
            // Both counters saturate at the same value, so err_cnt can
            // never overtake check_cnt.
            if (err_reg != CNT_MAX) begin
              err_next = err_reg + CNT_W'(1);
            end
            flag_next = 1'b1;
            if (!flag_reg) begin
              first_next = lane_mis;
            end
            if (STOP_ON_ERR) begin
              state_next = ST_FAIL;
            end
          end
        end

        ST_FAIL: begin
          // Everything frozen, including the mismatch vector that caused
          // the stop.
          state_next = ST_FAIL;
        end

        default: begin
          state_next = ST_IDLE;
          mis_next   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg <= ST_IDLE;
      warm_reg  <= '0;
      chk_reg   <= '0;
      err_reg   <= '0;
      flag_reg  <= 1'b0;
      first_reg <= '0;
      mis_reg   <= '0;
    end else begin
      state_reg <= state_next;
      warm_reg  <= warm_next;
      chk_reg   <= chk_next;
      err_reg   <= err_next;
      flag_reg  <= flag_next;
      first_reg <= first_next;
      mis_reg   <= mis_next;
    end
  end

  assign state          = state_reg;
  assign check_cnt      = chk_reg;
  assign err_cnt        = err_reg;
  assign err_flag       = flag_reg;
  assign first_err_lane = first_reg;
  assign mismatch       = mis_reg;

endmodule

// File: tb/tb_incr_checker.sv
// ---------------------------------------------------------------------------
// tb_incr_checker
//
// Directed bench for incr_checker. There are three instances:
//   u_a : defaults (STOP_ON_ERR=0, CNT_W=16)
//   u_b : STOP_ON_ERR=1
//   u_c : CNT_W=4, used to reach saturation
// All instances share the lane data and the reset. Only one instance is
// enabled at a time, and "sel" chooses which one the model tracks.
//
// Each clocked step pushes the expected mismatch vector for a CHECK cycle
// onto a queue. After the edge, it pops that vector and compares it with
// the registered mismatch output.
// ---------------------------------------------------------------------------
module tb_incr_checker;

  logic        clk;
  logic        reset_l;
  logic [1:0]  in_s,  out_s;
  logic [39:0] in_q,  out_q;
  logic [69:0] in_w,  out_w;

  logic en_a, clr_a, en_b, clr_b, en_c, clr_c;

  logic [1:0]  st_a, st_b, st_c;
  logic [15:0] chk_a, err_a, chk_b, err_b;
  logic [3:0]  chk_c, err_c;
  logic        flag_a, flag_b, flag_c;
  logic [2:0]  first_a, first_b, first_c;
  logic [2:0]  mis_a, mis_b, mis_c;

  int checks = 0;
  int errors = 0;

  // Model of the selected instance.
  int          sel;
  bit          stop_mode;
  int          cnt_max;
  bit          in_check;
  int          exp_chk, exp_err;
  logic        exp_flag;
  logic [2:0]  exp_first;
  logic [2:0]  sb[$];

  incr_checker u_a (
    .clk(clk), .reset_l(reset_l), .enable(en_a), .clear(clr_a),
    .in_small(in_s), .in_quad(in_q), .in_wide(in_w),
    .out_small(out_s), .out_quad(out_q), .out_wide(out_w),
    .state(st_a), .check_cnt(chk_a), .err_cnt(err_a), .err_flag(flag_a),
    .first_err_lane(first_a), .mismatch(mis_a)
  );

  incr_checker #(.STOP_ON_ERR(1'b1)) u_b (
    .clk(clk), .reset_l(reset_l), .enable(en_b), .clear(clr_b),
    .in_small(in_s), .in_quad(in_q), .in_wide(in_w),
    .out_small(out_s), .out_quad(out_q), .out_wide(out_w),
    .state(st_b), .check_cnt(chk_b), .err_cnt(err_b), .err_flag(flag_b),
    .first_err_lane(first_b), .mismatch(mis_b)
  );

  incr_checker #(.CNT_W(4)) u_c (
    .clk(clk), .reset_l(reset_l), .enable(en_c), .clear(clr_c),
    .in_small(in_s), .in_quad(in_q), .in_wide(in_w),
    .out_small(out_s), .out_quad(out_q), .out_wide(out_w),
    .state(st_c), .check_cnt(chk_c), .err_cnt(err_c), .err_flag(flag_c),
    .first_err_lane(first_c), .mismatch(mis_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Accessors for the selected instance
  // ---------------------------------------------------------------------
  function automatic logic [1:0] cur_state();
    case (sel)
      0:       return st_a;
      1:       return st_b;
      default: return st_c;
    endcase
  endfunction

  function automatic logic [15:0] cur_chk();
    case (sel)
      0:       return chk_a;
      1:       return chk_b;
      default: return {12'd0, chk_c};
    endcase
  endfunction

  function automatic logic [15:0] cur_err();
    case (sel)
      0:       return err_a;
      1:       return err_b;
      default: return {12'd0, err_c};
    endcase
  endfunction

  function automatic logic cur_flag();
    case (sel)
      0:       return flag_a;
      1:       return flag_b;
      default: return flag_c;
    endcase
  endfunction

  function automatic logic [2:0] cur_first();
    case (sel)
      0:       return first_a;
      1:       return first_b;
      default: return first_c;
    endcase
  endfunction

  function automatic logic [2:0] cur_mis();
    case (sel)
      0:       return mis_a;
      1:       return mis_b;
      default: return mis_c;
    endcase
  endfunction

  function automatic logic cur_en();
    case (sel)
      0:       return en_a;
      1:       return en_b;
      default: return en_c;
    endcase
  endfunction

  function automatic logic cur_clr();
    case (sel)
      0:       return clr_a;
      1:       return clr_b;
      default: return clr_c;
    endcase
  endfunction

  // Reference mismatch vector {wide, quad, small} for the current inputs.
  function automatic logic [2:0] exp_vec();
    logic [1:0]  es;
    logic [39:0] eq;
    logic [69:0] ew;
    es = in_s + 2'd1;
    eq = in_q + 40'd1;
    ew = in_w + 70'd1;
    return {(out_w != ew), (out_q != eq), (out_s != es)};
  endfunction

  // ---------------------------------------------------------------------
  // Comparison and stepping
  // ---------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".check_cnt"}, 32'(cur_chk()), 32'(exp_chk));
    chk({tag, ".err_cnt"},   32'(cur_err()), 32'(exp_err));
    chk({tag, ".err_flag"},  32'(cur_flag()), 32'(exp_flag));
    chk({tag, ".first"},     32'(cur_first()), 32'(exp_first));
  endtask

  task automatic model_zero();
    exp_chk   = 0;
    exp_err   = 0;
    exp_flag  = 1'b0;
    exp_first = 3'b000;
    in_check  = 1'b0;
  endtask

  task automatic tick();
    logic [2:0] v;
    v = exp_vec();
    if (cur_clr()) begin
      model_zero();
    end else if (!cur_en()) begin
      in_check = 1'b0;
    end else if (in_check) begin
      sb.push_back(v);
      if (exp_chk < cnt_max) exp_chk++;
      if (v != 3'b000) begin
        if (exp_err < cnt_max) exp_err++;
        if (!exp_flag) exp_first = v;
        exp_flag = 1'b1;
        if (stop_mode) in_check = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      v = sb.pop_front();
      chk("mismatch", 32'(cur_mis()), 32'(v));
    end
  endtask

  task automatic set_good();
    in_s = 2'd1;          out_s = 2'd2;
    in_q = 40'h00000000FF; out_q = 40'h0000000100;
    in_w = 70'd5;         out_w = 70'd6;
  endtask

  // Three edges from an enabled IDLE bring the instance into CHECK (WARMUP=2).
  task automatic warm_to_check(input string tag);
    tick(); chk({tag, ".state_w1"}, 32'(cur_state()), 32'd1);
    tick(); chk({tag, ".state_w2"}, 32'(cur_state()), 32'd1);
    tick(); chk({tag, ".state_chk"}, 32'(cur_state()), 32'd2);
    in_check = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    reset_l = 1'b0;
    en_a = 0; clr_a = 0; en_b = 0; clr_b = 0; en_c = 0; clr_c = 0;
    in_s = '0; out_s = '0; in_q = '0; out_q = '0; in_w = '0; out_w = '0;
    sel = 0; stop_mode = 0; cnt_max = 65535;
    model_zero();

    // Reset state, observed before any clock edge.
    #2;
    chk("reset.state", 32'(st_a), 32'd0);
    check_stats("reset");
    chk("reset.mismatch", 32'(mis_a), 32'd0);

    // Release reset, then run correct results on instance A.
    #10;
    reset_l = 1'b1;
    set_good();
    en_a = 1'b1;
    warm_to_check("a");
    for (int i = 0; i < 8; i++) tick();
    check_stats("a.good");

    // Wrap-around: all-ones inputs expect zero.
    in_s = 2'b11; out_s = 2'b00;
    in_q = {40{1'b1}}; out_q = '0;
    in_w = {70{1'b1}}; out_w = '0;
    for (int i = 0; i < 3; i++) tick();
    check_stats("a.wrap");

    // Single-lane error on quad for one cycle.
    set_good();
    out_q = 40'h0000000101;
    tick();
    set_good();
    tick();
    tick();
    check_stats("a.quad_err");

    // A later wide error counts, but the first-error lanes stay quad.
    out_w = 70'd7;
    tick();
    set_good();
    tick();
    check_stats("a.wide_err");

    // Clear in the same cycle as a mismatch: clear wins.
    out_s = 2'd0;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    set_good();
    chk("a.clr.state", 32'(st_a), 32'd0);
    chk("a.clr.mismatch", 32'(mis_a), 32'd0);
    check_stats("a.clr");

    // Re-enter through a full WARMUP, take one error, then drop enable.
    warm_to_check("a2");
    out_s = 2'd3;
    tick();
    set_good();
    en_a = 1'b0;
    tick();
    chk("a.dis.state", 32'(st_a), 32'd0);
    chk("a.dis.mismatch", 32'(mis_a), 32'd0);
    check_stats("a.dis");

    // Instance B: stop on the first error.
    sel = 1; stop_mode = 1; cnt_max = 65535;
    model_zero();
    en_b = 1'b1;
    warm_to_check("b");
    tick();
    in_s = 2'd1; out_s = 2'd3;
    in_q = 40'd5; out_q = 40'd5;
    in_w = 70'd7; out_w = 70'd0;
    tick();
    chk("b.fail.state", 32'(st_b), 32'd3);
    check_stats("b.fail");
    set_good();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b.frozen.state", 32'(st_b), 32'd3);
      chk("b.frozen.mismatch", 32'(mis_b), 32'h7);
      check_stats("b.frozen");
    end
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    en_b = 1'b0;
    chk("b.clr.state", 32'(st_b), 32'd0);
    chk("b.clr.mismatch", 32'(mis_b), 32'd0);
    check_stats("b.clr");

    // Instance C: 4-bit counters saturate.
    sel = 2; stop_mode = 0; cnt_max = 15;
    model_zero();
    set_good();
    en_c = 1'b1;
    warm_to_check("c");
    out_s = 2'd0;
    for (int i = 0; i < 20; i++) tick();
    chk("c.sat.state", 32'(st_c), 32'd2);
    check_stats("c.sat");

    // Reset in the middle of CHECK clears the state with no clock edge.
    #3;
    reset_l = 1'b0;
    #1;
    model_zero();
    chk("c.rst.state", 32'(st_c), 32'd0);
    chk("c.rst.mismatch", 32'(mis_c), 32'd0);
    check_stats("c.rst");
    chk("a.rst.err_cnt", 32'(err_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
